// File: rtl/unary_tx_4_11.sv
// Binary-to-unary frame transmitter: encodes two captured counts as thermometer-coded bit
// streams on A/B, then holds a downstream unary adder in write mode for a fixed drain period.
module unary_tx_4_11 #(
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned FRAME_LEN = 15,
   parameter int unsigned DRAIN_LEN = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [CNT_W-1:0] cnt_a,
   input  logic [CNT_W-1:0] cnt_b,
   output logic             A,
   output logic             B,
   output logic             en,
   output logic             read_or_write,
   output logic             frame_done
);

   localparam int unsigned      DrainW   = $clog2(DRAIN_LEN + 1);
   localparam logic [CNT_W-1:0] FrameMax = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] IdxOne   = CNT_W'(1);
   localparam logic [DrainW-1:0] DrainMax = DrainW'(DRAIN_LEN);
   localparam logic [DrainW-1:0] DrainOne = DrainW'(1);

   typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] sat_a, sat_b;
   logic [DrainW-1:0] drain_q, drain_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             en_q, en_d;
   logic             rw_q, rw_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;

   always_comb begin
      sat_a = (cnt_a > FrameMax) ? FrameMax : cnt_a;
      sat_b = (cnt_b > FrameMax) ? FrameMax : cnt_b;
   end

   // idx_q is the index of the next bit to drive; the visible bit is idx_q-1.
   // drain_q counts drain cycles already visible on the outputs.
   always_comb begin
      state_d = state_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      a_d     = 1'b0;
      b_d     = 1'b0;
      en_d    = 1'b0;
      rw_d    = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b0;
      case (state_q)
         StIdle: begin
            ready_d = 1'b1;
            if (load_valid) begin
               state_d = StStream;
               cnt_a_d = sat_a;
               cnt_b_d = sat_b;
               idx_d   = IdxOne;
               a_d     = (sat_a != '0);
               b_d     = (sat_b != '0);
               en_d    = 1'b1;
               ready_d = 1'b0;
            end
         end
         StStream: begin
            en_d = 1'b1;
            if (idx_q == FrameMax) begin
               state_d = StDrain;
               rw_d    = 1'b1;
               drain_d = DrainOne;
               done_d  = (DrainMax == DrainOne);
            end else begin
               a_d   = (idx_q < cnt_a_q);
               b_d   = (idx_q < cnt_b_q);
               idx_d = idx_q + IdxOne;
            end
         end
         StDrain: begin
            if (drain_q == DrainMax) begin
               state_d = StIdle;
               ready_d = 1'b1;
               idx_d   = '0;
               drain_d = '0;
            end else begin
               en_d    = 1'b1;
               rw_d    = 1'b1;
               drain_d = drain_q + DrainOne;
               done_d  = ((drain_q + DrainOne) == DrainMax);
            end
         end
         default: begin
            state_d = StIdle;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         idx_q   <= '0;
         drain_q <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         en_q    <= 1'b0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
         a_q     <= a_d;
         b_q     <= b_d;
         en_q    <= en_d;
         rw_q    <= rw_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign A             = a_q;
   assign B             = b_q;
   assign en            = en_q;
   assign read_or_write = rw_q;
   assign frame_done    = done_q;
   assign load_ready    = ready_q;

endmodule

// File: doc/unary_tx_4_11.md
UNARY_TX_4_11 -- requirements
Module: unary_tx_4_11

Interface
REQ-001 Parameter: CNT_W, default 4, width of each binary count operand.
REQ-002 Parameter: FRAME_LEN, default 15, bit-periods per unary frame; legal range 1..(2^CNT_W)-1.
REQ-003 Parameter: DRAIN_LEN, default 20, cycles the downstream adder is held in write mode after a frame; legal range >=1.
REQ-004 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: load_valid  input  1  a count pair is offered on cnt_a/cnt_b.
REQ-007 Port: load_ready  output  1  block can accept a count pair this cycle.
REQ-008 Port: cnt_a  input  CNT_W  binary count to encode on A.
REQ-009 Port: cnt_b  input  CNT_W  binary count to encode on B.
REQ-010 Port: A  output  1  thermometer-coded unary stream for operand a.
REQ-011 Port: B  output  1  thermometer-coded unary stream for operand b.
REQ-012 Port: en  output  1  enable to the unary adder; high for the whole frame and drain.
REQ-013 Port: read_or_write  output  1  0 = adder reads A/B, 1 = adder writes its result.
REQ-014 Port: frame_done  output  1  one-cycle pulse on the last drain cycle.

Function
REQ-015 The block SHALL implement states IDLE, STREAM and DRAIN.
REQ-016 In IDLE: load_ready=1, A=B=en=read_or_write=frame_done=0.
REQ-017 A load is accepted on a rising edge where load_valid=1 and load_ready=1; cnt_a/cnt_b are registered then; IDLE->STREAM, bit index k=0.
REQ-018 load_valid SHALL be ignored outside IDLE (load_ready=0 in STREAM and DRAIN); no queuing.
REQ-019 Accept at edge N: stream bit k is driven in cycle N+1+k, k=0..FRAME_LEN-1; A=(k<cnt_a), B=(k<cnt_b), all registered outputs.
REQ-020 Counts greater than FRAME_LEN SHALL saturate to FRAME_LEN (all ones); count 0 gives an all-zero frame.
REQ-021 en=1 and read_or_write=0 throughout STREAM.
REQ-022 After bit FRAME_LEN-1: STREAM->DRAIN; A=B=0, en=1, read_or_write=1 for exactly DRAIN_LEN cycles.
REQ-023 frame_done=1 only in the final DRAIN cycle; the next cycle is IDLE with load_ready=1.
REQ-024 Minimum accept-to-accept spacing SHALL be FRAME_LEN+DRAIN_LEN+1 cycles.
REQ-025 Bit index and drain counters SHALL be sized to hold FRAME_LEN and DRAIN_LEN without wrap; no counter wrap is architecturally visible.
REQ-026 Captured cnt_a/cnt_b SHALL NOT change during STREAM or DRAIN, regardless of input activity.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, clear all counters and captured counts, and drive A=B=en=read_or_write=frame_done=0 and load_ready=1 from the next cycle.
REQ-028 rst SHALL take priority over a simultaneous load; reset mid-STREAM or mid-DRAIN aborts the frame, and no frame_done is produced.
REQ-029 The first load after reset release SHALL be accepted on the first edge with rst=0 and load_valid=1.

Verification
REQ-030 Defaults: cnt_a=7, cnt_b=15, accept at edge N -> A=1 for cycles N+1..N+7, then 0 through N+15; B=1 for N+1..N+15; read_or_write=1 for N+16..N+35; frame_done at N+35.
REQ-031 cnt_a=0, cnt_b=0 -> A=B=0 for the whole frame; en and read_or_write timing identical to REQ-030.
REQ-032 CNT_W=5, FRAME_LEN=15, cnt_a=20 -> A saturates to 15 ones; no extra bits.
REQ-033 load_valid held high continuously with new values -> second accept exactly 36 cycles after the first; values offered mid-frame are not captured.
REQ-034 rst pulsed at stream bit 5 with load_valid=1 -> outputs all zero next cycle, no frame_done, no load captured on the reset edge; the next load frames correctly.
REQ-035 Bench SHALL chain this block to the unary adder and check that the adder's dout reflects cnt_a+cnt_b for the 7+15 and 0+0 cases.
